// File: rtl/regfile_pkg.sv
// Purpose: shared widths and types for the 3-read/1-write register file and its read-side front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: RF_DATA_WIDTH/RF_ADDR_WIDTH (shared with bram_3_1), OPC_TAG_WIDTH, rf_addr_t, rf_data_t, opc_req_t.
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 10;
  localparam int OPC_TAG_WIDTH = 8;
  localparam int OPC_NUM_OPS   = 3;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

  // Issue request as seen by the collector. Index 0 is operand 1.
  // "use" is a reserved word, hence use_mask.
  typedef struct packed {
    rf_addr_t [OPC_NUM_OPS-1:0] ra;
    logic     [OPC_NUM_OPS-1:0] use_mask;
    logic     [OPC_TAG_WIDTH-1:0] tag;
  } opc_req_t;

endpackage

// File: rtl/regfile_operand_collector_if.sv
// Purpose: bundles the issue request, register file read/snoop and operand output signals of the collector.
// Latency: n/a (wires only).
// Backpressure: req_ready / op_ready valid-ready pairs; rf side has none.
// Modports: slave = the collector itself, master = its environment (issue stage, register file, execute stage).
interface regfile_operand_collector_if import regfile_pkg::*; #(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int TAG_WIDTH  = OPC_TAG_WIDTH
) ();

  // issue request
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_ra1;
  logic [ADDR_WIDTH-1:0] req_ra2;
  logic [ADDR_WIDTH-1:0] req_ra3;
  logic [2:0]            req_use;
  logic [TAG_WIDTH-1:0]  req_tag;

  // register file read ports and write snoop
  logic [ADDR_WIDTH-1:0] rf_ra1;
  logic [ADDR_WIDTH-1:0] rf_ra2;
  logic [ADDR_WIDTH-1:0] rf_ra3;
  logic [DATA_WIDTH-1:0] rf_do1;
  logic [DATA_WIDTH-1:0] rf_do2;
  logic [DATA_WIDTH-1:0] rf_do3;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_wa;
  logic [DATA_WIDTH-1:0] rf_di;

  // operand bundle
  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] op_c;
  logic [TAG_WIDTH-1:0]  op_tag;

  modport slave (
    input  req_valid, req_ra1, req_ra2, req_ra3, req_use, req_tag,
    output req_ready,
    output rf_ra1, rf_ra2, rf_ra3,
    input  rf_do1, rf_do2, rf_do3, rf_we, rf_wa, rf_di,
    output op_valid, op_a, op_b, op_c, op_tag,
    input  op_ready
  );

  modport master (
    output req_valid, req_ra1, req_ra2, req_ra3, req_use, req_tag,
    input  req_ready,
    input  rf_ra1, rf_ra2, rf_ra3,
    output rf_do1, rf_do2, rf_do3, rf_we, rf_wa, rf_di,
    input  op_valid, op_a, op_b, op_c, op_tag,
    output op_ready
  );

endinterface

// File: rtl/rf_bypass_mux.sv
// Purpose: selects the value captured for one operand: zero, same-edge write data, or async read data.
// Latency: combinational.
// Backpressure: none.
// Ports: use_en/ra (operand enable and address), rf_do (read data), rf_we/rf_wa/rf_di (write snoop), operand (result).
module rf_bypass_mux import regfile_pkg::*; #(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  use_en,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rf_do,
  input  logic                  rf_we,
  input  logic [ADDR_WIDTH-1:0] rf_wa,
  input  logic [DATA_WIDTH-1:0] rf_di,
  output logic [DATA_WIDTH-1:0] operand
);

  // The write that commits on the capture edge is not yet visible on rf_do,
  // so take it straight from the write port.
  always_comb begin
    operand = '0;
    if (use_en) begin
      if (rf_we && (rf_wa == ra)) begin
        operand = rf_di;
      end else begin
        operand = rf_do;
      end
    end
  end

endmodule

// File: rtl/regfile_operand_collector.sv
// Purpose: drives the register file read ports from an address stage and captures bypassed operands into an output register.
// Latency: request accepted at edge k is captured at edge k+1; op_valid high the cycle after.
// Backpressure: req_ready = !s1_valid || !op_valid || op_ready; full (both stages held) stalls issue, nothing dropped.
// Ports: clk, rst_n (sync, active low), bus (slave modport: req_*, rf_*, op_*).
module regfile_operand_collector import regfile_pkg::*; #(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int TAG_WIDTH  = OPC_TAG_WIDTH
) (
  input logic                         clk,
  input logic                         rst_n,
  regfile_operand_collector_if.slave  bus
);

  // address stage
  logic                             s1_valid;
  logic [2:0][ADDR_WIDTH-1:0]       s1_ra;
  logic [2:0]                       s1_use;
  logic [TAG_WIDTH-1:0]             s1_tag;

  // output stage
  logic                             op_valid_q;
  logic [2:0][DATA_WIDTH-1:0]       op_q;
  logic [TAG_WIDTH-1:0]             op_tag_q;

  logic [2:0][DATA_WIDTH-1:0]       rf_do;
  logic [2:0][DATA_WIDTH-1:0]       cap;

  logic req_ready;
  logic accept;
  logic s2_load;
  logic op_fire;

  // s1 may refill on the same edge it hands its request to s2, so ready only
  // needs one of: s1 empty, s2 empty, or s2 being drained this edge.
  always_comb begin
    req_ready = !s1_valid || !op_valid_q || bus.op_ready;
    accept    = bus.req_valid && req_ready;
    s2_load   = s1_valid && (!op_valid_q || bus.op_ready);
    op_fire   = op_valid_q && bus.op_ready;
  end

  assign rf_do = {bus.rf_do3, bus.rf_do2, bus.rf_do1};

  for (genvar g = 0; g < 3; g++) begin : g_byp
    rf_bypass_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_byp (
      .use_en  (s1_use[g]),
      .ra      (s1_ra[g]),
      .rf_do   (rf_do[g]),
      .rf_we   (bus.rf_we),
      .rf_wa   (bus.rf_wa),
      .rf_di   (bus.rf_di),
      .operand (cap[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ra    <= '0;
      s1_use   <= '0;
      s1_tag   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_ra    <= {bus.req_ra3, bus.req_ra2, bus.req_ra1};
        s1_use   <= bus.req_use;
        s1_tag   <= bus.req_tag;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Output register only loads on s2_load, which keeps the bundle frozen
  // (a snapshot) while it waits for op_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_q       <= '0;
      op_tag_q   <= '0;
    end else begin
      if (s2_load) begin
        op_valid_q <= 1'b1;
        op_q       <= cap;
        op_tag_q   <= s1_tag;
      end else if (op_fire) begin
        op_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rf_ra1    = s1_ra[0];
  assign bus.rf_ra2    = s1_ra[1];
  assign bus.rf_ra3    = s1_ra[2];
  assign bus.op_valid  = op_valid_q;
  assign bus.op_a      = op_q[0];
  assign bus.op_b      = op_q[1];
  assign bus.op_c      = op_q[2];
  assign bus.op_tag    = op_tag_q;

endmodule

// File: doc/regfile_operand_collector.md
Name: regfile_operand_collector

Overview:
Read-side front end for the 3-read/1-write register file (bram_3_1). It accepts issue requests carrying up to three source register addresses and drives the register file's asynchronous read ports. It captures the three operands, forwarding any same-cycle write, and presents them downstream with a valid/ready handshake. The block sits between the warp issue stage and the execute stage, and sustains one request per clock.

Parameters:
DATA_WIDTH, 32, width of one register entry; must match the register file.
ADDR_WIDTH, 10, register address width; must match the register file.
TAG_WIDTH, 8, opaque instruction tag carried alongside the operands.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
req_valid  input  1  issue request valid.
req_ready  output  1  collector can accept a request this cycle.
req_ra1 / req_ra2 / req_ra3  input  ADDR_WIDTH each  source register addresses.
req_use  input  3  per-operand enable; bit i corresponds to operand i+1.
req_tag  input  TAG_WIDTH  instruction tag.
rf_ra1 / rf_ra2 / rf_ra3  output  ADDR_WIDTH each  register file read addresses.
rf_do1 / rf_do2 / rf_do3  input  DATA_WIDTH each  register file read data (combinational from rf_ra*).
rf_we  input  1  snooped register file write enable.
rf_wa  input  ADDR_WIDTH  snooped write address.
rf_di  input  DATA_WIDTH  snooped write data.
op_valid  output  1  operand bundle valid.
op_ready  input  1  downstream accepts the bundle.
op_a / op_b / op_c  output  DATA_WIDTH each  operands 1, 2, 3.
op_tag  output  TAG_WIDTH  tag of the presented bundle.

Behaviour:
- Reset: rst_n low at a rising edge clears s1_valid and op_valid, and zeroes all s1 fields, op_a/op_b/op_c and op_tag. rf_ra* therefore read 0. Reset mid-flight discards every in-flight request; nothing is replayed.
- Stage s1 (address stage):
  - A request is accepted on an edge where req_valid && req_ready.
  - s1 latches req_ra1..3, req_use and req_tag.
  - rf_ra1..3 are driven directly from the s1 address registers.
- Stage s2 (output register): s1 transfers to s2 when s1_valid && (!op_valid || op_ready).
- Capture and bypass, per operand i:
  - If use[i] == 0, capture 0.
  - Else if rf_we && rf_wa == s1_ra_i, capture rf_di (write-through for the write committing at that same edge).
  - Else capture rf_do_i.
- Snapshot semantics: a captured bundle reflects every write committed up to and including its capture edge. Writes after capture do not alter op_a/op_b/op_c. While a request waits in s1, later writes are observed naturally through the asynchronous read.
- Latency: a request accepted at edge k is captured at edge k+1, so op_valid is high in the cycle after edge k+1.
- req_ready = !s1_valid || !op_valid || op_ready. This is combinational from op_ready, and is the only combinational input-to-output path.
- Handshake rules:
  - Bundle consumed on an edge where op_valid && op_ready.
  - op_valid drops only on consumption without a refill, or on reset.
  - op_a/op_b/op_c and op_tag are stable while op_valid && !op_ready.
- Throughput: one request per cycle when op_ready is held high.
- Full condition (s1 and s2 both valid, op_ready low): req_ready = 0. No request is accepted or dropped while full.
- Simultaneous events: consume, capture and accept may all occur on the same edge.
- Duplicate addresses: the same register on multiple operands returns an identical value on each, with bypass applied to each independently.
- Write to an address not present in s1 has no effect on the bundle.
- req_valid low: s1 drains normally; rf_ra* hold the last s1 addresses (no requirement to idle them).

Decomposition:
- Package regfile_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults, shared with bram_3_1.
  - Typedef rf_addr_t, rf_data_t.
  - Struct opc_req_t {ra[3], use[3], tag}.
- Sub-module rf_bypass_mux, instantiated 3 times: inputs use, ra, rf_do, rf_we, rf_wa, rf_di; output is the captured operand value.

Test Plan:
1. Basic read:
   - Preload r5 = 0x11, r6 = 0x22, r7 = 0x33.
   - Request (5, 6, 7, use = 111, tag = 0x01) with op_ready = 1.
   - Expect op_valid 2 edges later with a/b/c = 0x11/0x22/0x33 and tag 0x01.
2. Same-edge bypass:
   - Request ra1 = 9 (r9 = 0xAA); at its capture edge, drive rf_we = 1, rf_wa = 9, rf_di = 0xBB.
   - Expect op_a = 0xBB. Repeat with rf_wa = 10 and expect op_a = 0xAA.
3. Stall and snapshot:
   - Hold op_ready = 0 with a bundle holding op_a = 0x11 from r5; then write r5 = 0x99.
   - Expect op_a to stay 0x11, and req_ready to fall once s1 also fills.
   - A second request on r5, waiting in s1, must return 0x99 after op_ready = 1.
4. Back-to-back streaming:
   - Send 8 consecutive requests, tags 0..7, with op_ready = 1.
   - Expect 8 consecutive op_valid cycles, tags in order, no bubbles, req_ready constantly 1.
5. Use mask and duplicates:
   - Request (3, 3, 4, use = 101) with r3 = 0x5 and r4 = 0x7.
   - Expect a = 0x5, b = 0, c = 0x7.
6. Reset mid-flight:
   - With both stages valid, assert rst_n = 0 for 1 edge.
   - Expect op_valid = 0, op_* = 0 and req_ready = 1 on the following cycle, and no stale bundle emitted afterwards.
